// File: rtl/restoring_div_pkg.sv
// Shared definitions for the restoring divider and its multiplier-based
// reconstructor: state encodings, default width and counter sizing.
package restoring_div_pkg;

    // Default operand width used by both the divider and the reconstructor.
    localparam int unsigned N_DEF = 4;

    // Iteration counter width for the default operand width.
    localparam int unsigned CNT_W_DEF = $clog2(N_DEF + 1);

    // State encodings kept as plain constants so existing encodings remain
    // bit-compatible with the legacy datapath.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t ADD  = 2'd2;

    // Iteration counter width for an arbitrary operand width.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // One add-shift iteration at the default width: conditionally add b into
    // the high accumulator, then shift {sum, lo} right by one.
    function automatic logic [2*N_DEF:0] add_shift_step(
        input logic [N_DEF:0]   hi,
        input logic [N_DEF-1:0] lo,
        input logic [N_DEF-1:0] b
    );
        logic [N_DEF+1:0] sum;
        sum = {1'b0, hi};
        if (lo[0]) begin
            sum = sum + {2'b00, b};
        end
        return {sum[N_DEF+1:1], sum[0], lo[N_DEF-1:1]};
    endfunction

endpackage

// File: rtl/restoring_multiplication.sv
// Sequential shift-and-add reconstructor: rebuilds a dividend from the
// divider's quotient, divisor and remainder as q*b + r, one iteration per
// clock, with a start/busy/done handshake and a remainder-range flag.
module restoring_multiplication
    import restoring_div_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     q,
    input  logic [N-1:0]     b,
    input  logic [N-1:0]     r,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   result,
    output logic             rem_err
);

    localparam int unsigned CW = cnt_width(N);

    state_t          state;
    logic [N:0]      hi;
    logic [N-1:0]    lo;
    logic [CW-1:0]   count;
    logic [N-1:0]    b_reg;
    logic [N-1:0]    r_reg;
    logic [N+1:0]    sum;

    // Conditional partial-product add for the current multiplier bit.
    always_comb begin
        sum = {1'b0, hi};
        if (lo[0]) begin
            sum = {1'b0, hi} + {2'b00, b_reg};
        end
    end

    // Handshake FSM and datapath registers; operands latched only on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
            b_reg   <= '0;
            r_reg   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            rem_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        b_reg <= b;
                        r_reg <= r;
                        hi    <= '0;
                        lo    <= q;
                        count <= CW'(N);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    hi    <= sum[N+1:1];
                    lo    <= {sum[0], lo[N-1:1]};
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state <= ADD;
                    end
                end
                ADD: begin
                    result  <= {hi[N-1:0], lo} + {{N{1'b0}}, r_reg};
                    rem_err <= (r_reg >= b_reg);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_multiplication.sv
// Directed testbench for restoring_multiplication (N=4).
module tb_restoring_multiplication;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] q;
    logic [3:0] b;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       rem_err;

    int checks;
    int failures;

    restoring_multiplication #(.N(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .q       (q),
        .b       (b),
        .r       (r),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rem_err (rem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; q = '0; b = '0; r = '0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, result, rem_err} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs busy=%0b done=%0b result=%0d rem_err=%0b expected all 0",
                     busy, done, result, rem_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Issue one operation and check latency, busy width, result and flag.
    task automatic test_op(input string name, input logic [3:0] qv, input logic [3:0] bv,
                           input logic [3:0] rv, input logic [7:0] exp_res, input logic exp_err);
        int lat;
        int busy_cnt;
        bit seen;
        q = qv; b = bv; r = rv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        q = ~qv; b = ~bv; r = ~rv;
        lat = 0; busy_cnt = 0; seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                lat = i;
            end
        end
        checks++;
        if (lat != 5) begin
            failures++;
            $display("FAIL %s latency got=%0d expected=5", name, lat);
        end
        checks++;
        if (busy_cnt != 5) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d expected=5", name, busy_cnt);
        end
        checks++;
        if (result !== exp_res) begin
            failures++;
            $display("FAIL %s result got=%0d expected=%0d", name, result, exp_res);
        end
        checks++;
        if (rem_err !== exp_err) begin
            failures++;
            $display("FAIL %s rem_err got=%0b expected=%0b", name, rem_err, exp_err);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_at_done got=%0b expected=0", name, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || result !== exp_res) begin
            failures++;
            $display("FAIL %s done_pulse_hold done=%0b result=%0d expected done=0 result=%0d",
                     name, done, result, exp_res);
        end
    endtask

    // A second start while busy, with changed operands, must not disturb the run.
    task automatic test_start_while_busy();
        int dones;
        int done_at;
        bit busy_bad;
        q = 4'd6; b = 4'd5; r = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; q = 4'd1; b = 4'd1; r = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; done_at = 0; busy_bad = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dones++;
                if (done_at == 0) done_at = i;
            end
            if (i < 3 && busy !== 1'b1) busy_bad = 1'b1;
            if (i >= 3 && busy !== 1'b0) busy_bad = 1'b1;
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL busy_start done_count got=%0d expected=1", dones);
        end
        checks++;
        if (done_at != 3) begin
            failures++;
            $display("FAIL busy_start done_edge got=%0d expected=3", done_at);
        end
        checks++;
        if (result !== 8'd31) begin
            failures++;
            $display("FAIL busy_start result got=%0d expected=31", result);
        end
        checks++;
        if (busy_bad) begin
            failures++;
            $display("FAIL busy_start busy_profile got=bad expected=high_until_done");
        end
    endtask

    // Asynchronous reset between edges mid-RUN discards the operation.
    task automatic test_reset_mid_run();
        bit any_done;
        q = 4'd9; b = 4'd7; r = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, result, rem_err} !== 11'd0) begin
            failures++;
            $display("FAIL async_reset busy=%0b done=%0b result=%0d rem_err=%0b expected all 0",
                     busy, done, result, rem_err);
        end
        #1;
        rst = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) any_done = 1'b1;
        end
        checks++;
        if (any_done) begin
            failures++;
            $display("FAIL async_reset activity_after got=busy_or_done expected=idle");
        end
        test_op("after_reset", 4'd3, 4'd4, 4'd2, 8'd14, 1'b0);
    endtask

    // start held high: one operation every N+2 = 6 cycles.
    task automatic test_back_to_back();
        int dones;
        int last;
        q = 4'd10; b = 4'd11; r = 4'd10; start = 1'b1;
        dones = 0; last = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dones++;
                checks++;
                if (i - last != 6) begin
                    failures++;
                    $display("FAIL b2b interval got=%0d expected=6", i - last);
                end
                checks++;
                if (result !== 8'd120 || rem_err !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b result got=%0d/%0b expected=120/0", result, rem_err);
                end
                last = i;
            end
        end
        checks++;
        if (dones != 5) begin
            failures++;
            $display("FAIL b2b done_count got=%0d expected=5", dones);
        end
        start = 1'b0;
        for (int i = 0; i < 10 && busy === 1'b1; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_op("q9_b7_r4",    4'd9,  4'd7,  4'd4,  8'd67,  1'b0);
        test_op("q15_b15_r14", 4'd15, 4'd15, 4'd14, 8'd239, 1'b0);
        test_op("all_zero",    4'd0,  4'd0,  4'd0,  8'd0,   1'b1);
        test_op("b_zero",      4'd5,  4'd0,  4'd3,  8'd3,   1'b1);
        test_op("r_eq_b",      4'd2,  4'd3,  4'd3,  8'd9,   1'b1);
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
